retire_arat: RTL and testbench

- Consumer of the ROB retire bundle. Holds the architectural register file (ARF) and the architectural alias table (ARAT: areg -> last retired preg).
- On a retired branch mispredict (pd_fail), runs a multi-cycle restore. The restore streams the ARAT to rename's speculative RAT and stalls rename until the restore finishes.
- Sits between the ROB retire port and rename/source-read logic.

---
 rtl/retire_arat.sv | 131 +++++++++++++
 tb/tb_retire_arat.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_arat.sv
// Retire-side architectural state: ARF, ARAT, retired count, and the
// mispredict restore that streams the ARAT into rename's speculative RAT.
module retire_arat #(
  parameter int unsigned COMMIT_WIDTH      = 2,
  parameter int unsigned AREG_NUM          = 32,
  parameter int unsigned PREG_W            = 7,
  parameter int unsigned XLEN              = 64,
  parameter int unsigned RESTORE_PER_CYCLE = 8,
  parameter int unsigned AREG_READ_PORTS   = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [COMMIT_WIDTH-1:0]                   retire_valid,
  input  logic [COMMIT_WIDTH*5-1:0]                 retire_dst,
  input  logic [COMMIT_WIDTH-1:0]                   retire_wen,
  input  logic [COMMIT_WIDTH*PREG_W-1:0]            retire_preg,
  input  logic [COMMIT_WIDTH*XLEN-1:0]              retire_data,
  input  logic [COMMIT_WIDTH-1:0]                   retire_pd_fail,
  input  logic [AREG_READ_PORTS*5-1:0]              rd_areg,
  output logic [AREG_READ_PORTS*XLEN-1:0]           rd_data,
  output logic                                      restore_valid,
  output logic [4:0]                                restore_base,
  output logic [RESTORE_PER_CYCLE*(PREG_W-1)-1:0]   restore_preg,
  output logic                                      rename_stall,
  output logic [63:0]                               retired_cnt
);

  localparam int unsigned PW       = PREG_W - 1;
  localparam int unsigned CntW     = $clog2(COMMIT_WIDTH + 1);
  localparam logic [4:0]  LastBase = 5'(AREG_NUM - RESTORE_PER_CYCLE);

  typedef enum logic {StIdle, StRestore} state_e;

  state_e              state_q;
  logic [XLEN-1:0]     arf_q  [AREG_NUM];
  logic [PW-1:0]       arat_q [AREG_NUM];
  logic [COMMIT_WIDTH-1:0] eff;
  logic [CntW-1:0]     eff_cnt;
  logic                start_restore;
  logic                lane_ok;
  logic [COMMIT_WIDTH-1:0] unused_preg_msb;

  // A lane retires only if every lower lane retired and none was a mispredict.
  always_comb begin
    eff           = '0;
    eff_cnt       = '0;
    start_restore = 1'b0;
    lane_ok       = (state_q == StIdle);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      eff[i]        = lane_ok && retire_valid[i];
      lane_ok       = eff[i] && !retire_pd_fail[i];
      eff_cnt       = eff_cnt + CntW'(eff[i]);
      start_restore = start_restore || (eff[i] && retire_pd_fail[i]);
    end
  end

  // ROB wrap bit of each retire preg id is not architectural.
  always_comb begin
    unused_preg_msb = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      unused_preg_msb[i] = retire_preg[i*PREG_W + PW];
    end
  end

  // Later lanes are written after earlier ones, so the highest lane wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < AREG_NUM; a++) begin
        arf_q[a]  <= '0;
        arat_q[a] <= PW'(a);
      end
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (eff[i] && retire_wen[i] && (retire_dst[i*5 +: 5] != 5'd0)) begin
          arf_q[retire_dst[i*5 +: 5]]  <= retire_data[i*XLEN +: XLEN];
          arat_q[retire_dst[i*5 +: 5]] <= retire_preg[i*PREG_W +: PW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      restore_valid <= 1'b0;
      rename_stall  <= 1'b0;
      restore_base  <= '0;
      retired_cnt   <= '0;
    end else begin
      retired_cnt <= retired_cnt + 64'(eff_cnt);
      unique case (state_q)
        StIdle: begin
          if (start_restore) begin
            state_q       <= StRestore;
            restore_valid <= 1'b1;
            rename_stall  <= 1'b1;
            restore_base  <= '0;
          end
        end
        StRestore: begin
          if (restore_base == LastBase) begin
            state_q       <= StIdle;
            restore_valid <= 1'b0;
            rename_stall  <= 1'b0;
            restore_base  <= '0;
          end else begin
            restore_base <= restore_base + 5'(RESTORE_PER_CYCLE);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < AREG_READ_PORTS; p++) begin
      if (rd_areg[p*5 +: 5] != 5'd0) begin
        rd_data[p*XLEN +: XLEN] = arf_q[rd_areg[p*5 +: 5]];
      end
    end
  end

  always_comb begin
    restore_preg = '0;
    for (int j = 0; j < RESTORE_PER_CYCLE; j++) begin
      restore_preg[j*PW +: PW] = arat_q[restore_base + 5'(j)];
    end
  end

endmodule

// File: tb/tb_retire_arat.sv
// Scoreboard bench for retire_arat: a plain-array model predicts reads, count
// and restore chunks; a negedge monitor pops and compares.
module tb_retire_arat;
  localparam int CW = 2, PW = 7, XL = 64, RPC = 8, RP = 2, AN = 32, AW = PW - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [CW-1:0]        retire_valid, retire_wen, retire_pd_fail;
  logic [CW*5-1:0]      retire_dst;
  logic [CW*PW-1:0]     retire_preg;
  logic [CW*XL-1:0]     retire_data;
  logic [RP*5-1:0]      rd_areg;
  logic [RP*XL-1:0]     rd_data;
  logic                 restore_valid, rename_stall;
  logic [4:0]           restore_base;
  logic [RPC*AW-1:0]    restore_preg;
  logic [63:0]          retired_cnt;

  retire_arat dut (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_wen(retire_wen),
    .retire_preg(retire_preg), .retire_data(retire_data), .retire_pd_fail(retire_pd_fail),
    .rd_areg(rd_areg), .rd_data(rd_data),
    .restore_valid(restore_valid), .restore_base(restore_base), .restore_preg(restore_preg),
    .rename_stall(rename_stall), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RP*XL-1:0] rd; logic [63:0] cnt; logic rv; } chk_t;
  typedef struct { logic [4:0] base; logic [RPC*AW-1:0] preg; } chunk_t;

  chk_t   chk_q[$];
  chunk_t chunk_q[$];
  int total = 0, bad = 0;

  logic [XL-1:0] m_arf  [AN];
  logic [AW-1:0] m_arat [AN];
  logic [63:0]   m_cnt;
  int            m_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < AN; a++) begin
      m_arf[a]  = '0;
      m_arat[a] = AW'(a);
    end
    m_cnt  = '0;
    m_left = 0;
    chk_q.delete();
    chunk_q.delete();
  endtask

  // One clock of stimulus; the expectation for this cycle is queued for the monitor.
  task automatic cycle(input logic [1:0] v, input logic [9:0] dst, input logic [1:0] wen,
                       input logic [13:0] preg, input logic [127:0] data,
                       input logic [1:0] pdf, input logic [9:0] rda);
    chk_t   c;
    chunk_t k;
    bit     stop, fail;
    logic [4:0] d;
    @(posedge clk); #1;
    retire_valid = v; retire_dst = dst; retire_wen = wen;
    retire_preg = preg; retire_data = data; retire_pd_fail = pdf; rd_areg = rda;
    for (int p = 0; p < RP; p++) c.rd[p*XL +: XL] = m_arf[rda[p*5 +: 5]];
    c.cnt = m_cnt;
    c.rv  = (m_left > 0);
    chk_q.push_back(c);
    if (m_left > 0) begin
      m_left--;
    end else begin
      stop = 0;
      fail = 0;
      for (int i = 0; i < CW; i++) begin
        if (!stop && v[i]) begin
          m_cnt++;
          d = dst[i*5 +: 5];
          if (wen[i] && d != 0) begin
            m_arf[d]  = data[i*XL +: XL];
            m_arat[d] = preg[i*PW +: AW];
          end
          if (pdf[i]) begin
            fail = 1;
            stop = 1;
          end
        end else begin
          stop = 1;
        end
      end
      if (fail) begin
        m_left = AN / RPC;
        for (int ch = 0; ch < AN / RPC; ch++) begin
          k.base = 5'(ch * RPC);
          for (int j = 0; j < RPC; j++) k.preg[j*AW +: AW] = m_arat[ch*RPC + j];
          chunk_q.push_back(k);
        end
      end
    end
  endtask

  task automatic idle(input logic [9:0] rda);
    cycle(2'b00, '0, 2'b00, '0, '0, 2'b00, rda);
  endtask

  // Reset pulse while the second restore chunk is on the outputs.
  task automatic reset_mid();
    @(posedge clk); #1;
    check("pre-reset restore_valid", restore_valid, 1);
    check("pre-reset restore_base", restore_base, 8);
    retire_valid = '0; retire_pd_fail = '0;
    #1 reset = 1'b0;
    #1;
    check("async reset restore_valid", restore_valid, 0);
    check("async reset rename_stall", rename_stall, 0);
    check("async reset retired_cnt", retired_cnt, 0);
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    chk_t   c;
    chunk_t k;
    forever begin
      @(negedge clk);
      if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check("rd_data0", rd_data[XL-1:0], c.rd[XL-1:0]);
        check("rd_data1", rd_data[2*XL-1:XL], c.rd[2*XL-1:XL]);
        check("retired_cnt", retired_cnt, c.cnt);
        check("restore_valid", restore_valid, c.rv);
        check("rename_stall", rename_stall, c.rv);
        if (c.rv && restore_valid) begin
          if (chunk_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL restore chunk: got base %0d want none", restore_base);
          end else begin
            k = chunk_q.pop_front();
            check("restore_base", restore_base, k.base);
            check("restore_preg", restore_preg, k.preg);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [1:0]   v, wen, pdf;
    logic [9:0]   dst, rda;
    logic [13:0]  preg;
    logic [127:0] data;
    reset = 1'b0;
    retire_valid = '0; retire_dst = '0; retire_wen = '0; retire_preg = '0;
    retire_data = '0; retire_pd_fail = '0; rd_areg = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Post-reset idle reads.
    idle({5'd0, 5'd5});
    repeat (3) idle({5'd3, 5'd7});
    // Same dst in both lanes: lane 1 wins.
    cycle(2'b11, {5'd3, 5'd3}, 2'b11, {7'h46, 7'h45}, {64'hBB, 64'hAA}, 2'b00, {5'd3, 5'd3});
    idle({5'd0, 5'd3});
    // Mispredict on lane 1 with its own write.
    cycle(2'b11, {5'd7, 5'd1}, 2'b10, {7'h12, 7'h00}, {64'h1, 64'h0}, 2'b10, {5'd7, 5'd3});
    repeat (4) idle({5'd7, 5'd3});
    idle({5'd7, 5'd1});
    // Mispredict on lane 0 blocks lane 1; retire during restore is dropped.
    cycle(2'b11, {5'd9, 5'd2}, 2'b10, {7'h33, 7'h00}, {64'h99, 64'h0}, 2'b01, {5'd9, 5'd2});
    idle({5'd9, 5'd4});
    cycle(2'b01, {5'd0, 5'd4}, 2'b01, {7'h00, 7'h2A}, {64'h0, 64'h5}, 2'b00, {5'd9, 5'd4});
    idle({5'd9, 5'd4});
    idle({5'd9, 5'd4});
    idle({5'd9, 5'd4});
    // Reset during chunk 1, then confirm the ARAT is back to identity.
    cycle(2'b01, {5'd0, 5'd11}, 2'b01, {7'h00, 7'h7F}, {64'h0, 64'h77}, 2'b01, {5'd3, 5'd11});
    idle({5'd3, 5'd11});
    reset_mid();
    idle({5'd3, 5'd11});
    cycle(2'b01, '0, 2'b00, '0, '0, 2'b01, {5'd7, 5'd3});
    repeat (5) idle({5'd7, 5'd3});

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      v    = 2'($urandom_range(0, 3));
      wen  = 2'($urandom_range(0, 3));
      dst  = 10'($urandom);
      preg = 14'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom};
      pdf  = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
      rda  = 10'($urandom);
      cycle(v, dst, wen, preg, data, pdf, rda);
    end
    repeat (6) idle(10'($urandom));
    @(negedge clk);
    #1;
    check("scoreboard drained", 64'(chk_q.size()), 0);
    check("restore chunks drained", 64'(chunk_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
